// File: rtl/ctrl_stack.sv
// -----------------------------------------------------------------------------
// ctrl_stack
//
// Control-flow state unit for the pipelined processor. It holds two stacks:
//   * the return-address (call) stack, written by fetch through call/ret, and
//   * the per-lane enable-mask stack, driven by stage 2 through
//     popen/pushen/allen/jumpf_fail.
// The call stack tracks how many entries are valid, reports full/empty, and
// has defined behaviour on overflow and underflow. A stall freezes all state.
//
// Parameters
//   AW          return-address width in bits
//   DEPTH       call-stack entries (>= 2)
//   EDEPTH      enable-stack bits (>= 2)
//   RET_OFFSET  added to the top entry to form ret_pc (wraps modulo 2^AW)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low (0 = reset)
//   stall       1 = hold every register, including cs_err
//   call        push call_pc onto the call stack
//   call_pc     address pushed on call
//   ret         pop the call stack
//   ret_pc      entry[0] + RET_OFFSET (combinational from the top entry)
//   cs_count    number of valid call-stack entries
//   cs_full     cs_count == DEPTH
//   cs_empty    cs_count == 0
//   jumpf_fail  clear enable bit 0
//   allen       set enable bit 0
//   pushen      duplicate enable bit 0 (shift left)
//   popen       pop the enable stack (shift right, top bit replicated)
//   enabled     enable-stack bit 0 (registered)
//   cs_err      sticky overflow/underflow flag
//
// Build option
//   CTRL_STACK_ERR_EN  when defined, cs_err is set by a call while full (without
//                      ret) or a ret while empty (without call) and stays set
//                      until reset. When undefined, cs_err is tied to 0 and no
//                      error logic exists. Stack data behaviour is the same in
//                      both builds.
// -----------------------------------------------------------------------------
module ctrl_stack #(
  parameter int AW         = 16,
  parameter int DEPTH      = 4,
  parameter int EDEPTH     = 32,
  parameter int RET_OFFSET = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       call,
  input  logic [AW-1:0]              call_pc,
  input  logic                       ret,
  output logic [AW-1:0]              ret_pc,
  output logic [$clog2(DEPTH+1)-1:0] cs_count,
  output logic                       cs_full,
  output logic                       cs_empty,
  input  logic                       jumpf_fail,
  input  logic                       allen,
  input  logic                       pushen,
  input  logic                       popen,
  output logic                       enabled,
  output logic                       cs_err
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0] OFFSET_C = AW'(RET_OFFSET);

  // ---------------------------------------------------------------------------
  // Call stack storage and status
  // ---------------------------------------------------------------------------
  logic [AW-1:0] cs_entry_reg  [DEPTH];
  logic [AW-1:0] cs_entry_next [DEPTH];
  logic [CW-1:0] cs_count_reg;
  logic [CW-1:0] cs_count_next;

  logic full_w;
  logic empty_w;

  assign full_w   = (cs_count_reg == DEPTH_C);
  assign empty_w  = (cs_count_reg == '0);
  assign cs_full  = full_w;
  assign cs_empty = empty_w;
  assign cs_count = cs_count_reg;

  // Top entry plus offset; wraps naturally at AW bits.
  assign ret_pc = cs_entry_reg[0] + OFFSET_C;

  // ---------------------------------------------------------------------------
  // Call-stack operation decode
  //   push : call without ret  (shift up, oldest entry falls off when full)
  //   pop  : ret without call, only when something is there to pop
  //   swap : call and ret together replace the top entry in place
  // A ret on an empty stack leaves the entries untouched.
  // ---------------------------------------------------------------------------
  logic do_push;
  logic do_pop;
  logic do_swap;

  assign do_push = call & ~ret;
  assign do_pop  = ret & ~call & ~empty_w;
  assign do_swap = call & ret;

  // Next value for each entry, built per slot so the edge slots need no
  // out-of-range neighbours.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == 0) begin : g_top
        always_comb begin
          cs_entry_next[gi] = cs_entry_reg[gi];
          if (do_push || do_swap) begin
            cs_entry_next[gi] = call_pc;
          end else if (do_pop) begin
            cs_entry_next[gi] = cs_entry_reg[gi+1];
          end
        end
      end else if (gi == DEPTH - 1) begin : g_bottom
        always_comb begin
          cs_entry_next[gi] = cs_entry_reg[gi];
          if (do_push) begin
            cs_entry_next[gi] = cs_entry_reg[gi-1];
          end else if (do_pop) begin
            cs_entry_next[gi] = '0;
          end
        end
      end else begin : g_mid
        always_comb begin
          cs_entry_next[gi] = cs_entry_reg[gi];
          if (do_push) begin
            cs_entry_next[gi] = cs_entry_reg[gi-1];
          end else if (do_pop) begin
            cs_entry_next[gi] = cs_entry_reg[gi+1];
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cs_entry_reg[gi] <= '0;
        end else if (!stall) begin
          cs_entry_reg[gi] <= cs_entry_next[gi];
        end
      end
    end
  endgenerate

  // Count saturates at DEPTH on push and floors at 0 on pop; a swap is neutral.
  always_comb begin
    cs_count_next = cs_count_reg;
    if (do_push && !full_w) begin
      cs_count_next = cs_count_reg + CW'(1);
    end else if (do_pop) begin
      cs_count_next = cs_count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_count_reg <= '0;
    end else if (!stall) begin
      cs_count_reg <= cs_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Enable-mask stack
  //   One operation per cycle, priority popen > pushen > allen > jumpf_fail.
  //   Pop replicates the top bit so an empty-looking stack stays enabled;
  //   push duplicates bit 0 and drops the top bit.
  // ---------------------------------------------------------------------------
  logic [EDEPTH-1:0] en_stack_reg;
  logic [EDEPTH-1:0] en_stack_next;

  always_comb begin
    en_stack_next = en_stack_reg;
    if (popen) begin
      en_stack_next = {en_stack_reg[EDEPTH-1], en_stack_reg[EDEPTH-1:1]};
    end else if (pushen) begin
      en_stack_next = {en_stack_reg[EDEPTH-2:0], en_stack_reg[0]};
    end else if (allen) begin
      en_stack_next[0] = 1'b1;
    end else if (jumpf_fail) begin
      en_stack_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_stack_reg <= '1;
    end else if (!stall) begin
      en_stack_reg <= en_stack_next;
    end
  end

  assign enabled = en_stack_reg[0];

  // ---------------------------------------------------------------------------
  // Sticky overflow/underflow flag
  // ---------------------------------------------------------------------------
`ifdef CTRL_STACK_ERR_EN
  logic cs_err_reg;
  logic err_event;

  // A simultaneous call+ret is a replace and never counts as an error.
  assign err_event = (call & ~ret & full_w) | (ret & ~call & empty_w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_err_reg <= 1'b0;
    end else if (!stall && err_event) begin
      cs_err_reg <= 1'b1;
    end
  end

  assign cs_err = cs_err_reg;
`else
  assign cs_err = 1'b0;
`endif

endmodule
